aes_feedback_cipher_stream: RTL and testbench

Parametrised successor to the byte-wide AES S-box feedback cipher. It processes NBYTES-wide blocks, each byte lane passing through its own AES S-box. It supports runtime-selected CFB or OFB mode for both encrypt and decrypt, and uses a valid/ready handshake on both input and output with a one-entry output register. It sits between a byte-block source (DMA/UART framer) and a sink that may apply backpressure.

---
 rtl/aes_fc_pkg.sv | 50 +++++
 rtl/aes_sbox.sv | 12 +
 rtl/aes_sbox_word.sv | 19 +
 rtl/aes_feedback_cipher_stream.sv | 112 +++++++++++
 tb/tb_aes_feedback_cipher_stream.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_fc_pkg.sv
// Shared types and GF(2^8) helpers for the AES S-box feedback cipher stream.
// Contents: feedback mode and FSM state enums, byte width, and the
// field arithmetic used to build the AES S-box from its algebraic definition.
package aes_fc_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    FC_CFB = 1'b0,
    FC_OFB = 1'b1
  } fc_mode_e;

  typedef enum logic {
    FC_IDLE = 1'b0,
    FC_RUN  = 1'b1
  } fc_state_e;

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] t;
    r = 8'h01;
    t = a;
    for (int unsigned i = 0; i < 7; i++) begin
      t = gf_mul(t, t);
      r = gf_mul(r, t);
    end
    return r;
  endfunction

  // AES affine output transform: x ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  function automatic logic [7:0] sbox_affine(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^
           {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single-byte AES S-box, purely combinational.
// Ports: data_i - input byte; data_o - substituted byte.
module aes_sbox
  import aes_fc_pkg::*;
(
  input  logic [BYTE_W-1:0] data_i,
  output logic [BYTE_W-1:0] data_o
);

  assign data_o = sbox_affine(gf_inv(data_i));

endmodule

// File: rtl/aes_sbox_word.sv
// NBYTES independent AES S-box lanes; lane k maps bits [8k+7:8k].
// Ports: data_i - W-bit word in; data_o - bytewise substituted word out.
module aes_sbox_word
  import aes_fc_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic [BYTE_W*NBYTES-1:0] data_i,
  output logic [BYTE_W*NBYTES-1:0] data_o
);

  for (genvar k = 0; k < NBYTES; k++) begin : g_lane
    aes_sbox u_sbox (
      .data_i (data_i[BYTE_W*k +: BYTE_W]),
      .data_o (data_o[BYTE_W*k +: BYTE_W])
    );
  end

endmodule

// File: rtl/aes_feedback_cipher_stream.sv
// Block-wide AES S-box feedback cipher (CFB/OFB, encrypt/decrypt) with
// valid/ready on both sides and a one-entry output register.
// Ports:
//   clk, rst          - rising-edge clock, async active-low reset
//   new_msg           - start message: iv<=key, latch enc_dec/mode, clear count
//   enc_dec, mode     - 1=encrypt/0=decrypt, 0=CFB/1=OFB (sampled with new_msg)
//   key               - initial IV
//   in_valid/in_ready/in_msg     - input block handshake
//   out_valid/out_ready/out_msg  - output block handshake
//   blk_cnt           - blocks accepted since the last new_msg (wraps)
module aes_feedback_cipher_stream
  import aes_fc_pkg::*;
#(
  parameter int unsigned NBYTES = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     new_msg,
  input  logic                     enc_dec,
  input  logic                     mode,
  input  logic [BYTE_W*NBYTES-1:0] key,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BYTE_W*NBYTES-1:0] in_msg,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W*NBYTES-1:0] out_msg,
  output logic [CNT_W-1:0]         blk_cnt
);

  localparam int unsigned W = BYTE_W * NBYTES;

  fc_state_e        state_q, state_d;
  fc_mode_e         mode_q, mode_d;
  logic             enc_dec_q, enc_dec_d;
  logic [W-1:0]     iv_q, iv_d;
  logic [W-1:0]     out_msg_q, out_msg_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
  logic [W-1:0]     ks;
  logic             accept;

  aes_sbox_word #(.NBYTES(NBYTES)) u_ks (
    .data_i (iv_q),
    .data_o (ks)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FC_IDLE;
      mode_q      <= FC_CFB;
      enc_dec_q   <= 1'b0;
      iv_q        <= '0;
      out_msg_q   <= '0;
      out_valid_q <= 1'b0;
      blk_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      enc_dec_q   <= enc_dec_d;
      iv_q        <= iv_d;
      out_msg_q   <= out_msg_d;
      out_valid_q <= out_valid_d;
      blk_cnt_q   <= blk_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    enc_dec_d   = enc_dec_q;
    iv_d        = iv_q;
    out_msg_d   = out_msg_q;
    out_valid_d = out_valid_q;
    blk_cnt_d   = blk_cnt_q;

    // The output slot frees this cycle if it is empty or being drained,
    // which lets accept and drain overlap for one block per cycle.
    in_ready = (state_q == FC_RUN) && !new_msg && (!out_valid_q || out_ready);
    accept   = in_valid && in_ready;

    if (new_msg) begin
      state_d     = FC_RUN;
      mode_d      = fc_mode_e'(mode);
      enc_dec_d   = enc_dec;
      iv_d        = key;
      out_valid_d = 1'b0;
      blk_cnt_d   = '0;
    end else if (accept) begin
      out_msg_d   = in_msg ^ ks;
      out_valid_d = 1'b1;
      blk_cnt_d   = blk_cnt_q + CNT_W'(1);
      // CFB feeds back the ciphertext: the output when encrypting, the input
      // when decrypting. OFB feeds back the keystream regardless of direction.
      if (mode_q == FC_OFB) begin
        iv_d = ks;
      end else if (enc_dec_q) begin
        iv_d = in_msg ^ ks;
      end else begin
        iv_d = in_msg;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_msg   = out_msg_q;
  assign blk_cnt   = blk_cnt_q;

endmodule

// File: tb/tb_aes_feedback_cipher_stream.sv
module tb_aes_feedback_cipher_stream;

  localparam int unsigned NB = 2;
  localparam int unsigned W  = 8 * NB;
  localparam int unsigned CW = 16;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          new_msg = 1'b0, enc_dec = 1'b0, mode = 1'b0;
  logic [W-1:0]  key = '0, in_msg = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, out_valid;
  logic          out_ready;
  logic [W-1:0]  out_msg;
  logic [CW-1:0] blk_cnt;

  logic bp_en = 1'b0, bp_rnd = 1'b1, or_dir = 1'b1;
  assign out_ready = bp_en ? bp_rnd : or_dir;

  int n_chk = 0;
  int n_fail = 0;
  int unsigned cyc = 0;
  logic [W-1:0] exp_q [$];

  // Reference model state: the feedback register and counter as the
  // cipher definition describes them.
  logic [W-1:0] m_iv;
  logic         m_enc, m_ofb;
  int unsigned  m_cnt;

  aes_feedback_cipher_stream #(.NBYTES(NB), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .new_msg   (new_msg),
    .enc_dec   (enc_dec),
    .mode      (mode),
    .key       (key),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_msg    (in_msg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_msg   (out_msg),
    .blk_cnt   (blk_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    bp_rnd = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] keystream(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int k = 0; k < int'(NB); k++) r[8*k +: 8] = SBOX[v[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [W-1:0] model_step(input logic [W-1:0] p);
    logic [W-1:0] ks, o;
    ks = keystream(m_iv);
    o  = p ^ ks;
    if (m_ofb)      m_iv = ks;
    else if (m_enc) m_iv = o;
    else            m_iv = p;
    m_cnt = m_cnt + 1;
    return o;
  endfunction

  // Monitor: every output handshake pops one expected word.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_output", {16'h0, out_msg}, 32'hDEAD_0000);
      else chk("out_msg", {16'h0, out_msg}, {16'h0, exp_q.pop_front()});
    end
  end

  task automatic start_msg(input logic [W-1:0] k, input logic e, input logic m);
    new_msg = 1'b1; key = k; enc_dec = e; mode = m;
    @(posedge clk); #1;
    new_msg = 1'b0;
    m_iv = k; m_enc = e; m_ofb = m; m_cnt = 0;
  endtask

  // kind: 0 = model expectation, 1 = given constant, 2 = word will be discarded
  task automatic send(input logic [W-1:0] w, input int kind, input logic [W-1:0] c);
    logic [W-1:0] e;
    int unsigned n;
    bit ok;
    n = 0; ok = 0;
    in_valid = 1'b1; in_msg = w;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (in_ready) ok = 1; else n++;
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    e = model_step(w);
    if (kind == 1) e = c;
    if (kind != 2) exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int unsigned n;
    bp_en = 1'b0; or_dir = 1'b1; in_valid = 1'b0;
    n = 0;
    while (out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int unsigned t0, nsend;
    // Reset values and IDLE behaviour.
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_msg", {16'h0, out_msg}, 32'd0);
    chk("rst_blk_cnt", {16'h0, blk_cnt}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b1; in_msg = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_in_ready", {31'd0, in_ready}, 32'd0);
      chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    // new_msg with simultaneous in_valid: word must not be consumed.
    new_msg = 1'b1; key = '0; enc_dec = 1'b1; mode = 1'b0;
    @(negedge clk);
    chk("newmsg_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    new_msg = 1'b0; in_valid = 1'b0;
    m_iv = '0; m_enc = 1'b1; m_ofb = 1'b0; m_cnt = 0;
    chk("newmsg_blk_cnt", {16'h0, blk_cnt}, 32'd0);
    chk("newmsg_out_valid", {31'd0, out_valid}, 32'd0);

    // CFB encrypt from zero IV.
    send(16'h1234, 1, 16'h7157);
    send(16'h0000, 1, 16'hA35B);
    drain();
    chk("cfb_enc_cnt", {16'h0, blk_cnt}, 32'd2);
    // CFB decrypt round trip.
    start_msg('0, 1'b0, 1'b0);
    send(16'h7157, 1, 16'h1234);
    send(16'hA35B, 1, 16'h0000);
    drain();
    // OFB, both directions give the same stream.
    for (int d = 0; d < 2; d++) begin
      start_msg('0, d[0], 1'b1);
      send(16'h0000, 1, 16'h6363);
      send(16'h0000, 1, 16'hFBFB);
      drain();
    end

    // Backpressure hold, then release with accept+drain overlap.
    start_msg('0, 1'b1, 1'b0);
    or_dir = 1'b0;
    send(16'h1234, 1, 16'h7157);
    in_valid = 1'b1; in_msg = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_out_msg", {16'h0, out_msg}, 32'h7157);
    end
    @(posedge clk); #1;
    or_dir = 1'b1;
    send(16'h0000, 1, 16'hA35B);
    t0 = cyc;
    for (int i = 0; i < 8; i++) send(W'($urandom), 0, '0);
    chk("throughput_cycles", cyc - t0, 32'd8);
    drain();
    chk("bp_blk_cnt", {16'h0, blk_cnt}, 32'd10);

    // new_msg discards a held output.
    start_msg(W'($urandom), 1'b1, 1'b0);
    or_dir = 1'b0;
    send(W'($urandom), 2, '0);
    in_valid = 1'b0;
    start_msg(W'($urandom), 1'b1, 1'b0);
    chk("discard_out_valid", {31'd0, out_valid}, 32'd0);
    chk("discard_blk_cnt", {16'h0, blk_cnt}, 32'd0);
    or_dir = 1'b1;

    // Randomised messages under random backpressure.
    for (int m = 0; m < 6; m++) begin
      drain();
      start_msg(W'($urandom), 1'($urandom), 1'($urandom));
      bp_en = 1'b1;
      nsend = $urandom_range(5, 20);
      for (int i = 0; i < int'(nsend); i++) begin
        enc_dec = 1'($urandom);
        mode = 1'($urandom);
        send(W'($urandom), 0, '0);
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b0;
      chk("rand_blk_cnt", {16'h0, blk_cnt}, m_cnt);
    end
    drain();

    // Asynchronous reset mid-stream.
    start_msg(W'($urandom), 1'b1, 1'b1);
    or_dir = 1'b0;
    send(W'($urandom), 2, '0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_msg", {16'h0, out_msg}, 32'd0);
    chk("arst_blk_cnt", {16'h0, blk_cnt}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    or_dir = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
